// File: rtl/cd_tx_sched_pkg.sv
// Shared types and constants for the CDBUS transmit read-side sequencer.
package cd_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GRANT,
    FETCH_LEN,
    LOAD,
    SEND,
    WAIT_DONE
  } cd_tx_state_e;

  // Bytes in front of the payload: addr, dst, len.
  localparam int HDR_BYTES = 3;
  // Byte offset of the length field inside the header.
  localparam int LEN_OFS   = 2;

endpackage

// File: rtl/cd_tx_sched_if.sv
// Byte stream from the transmit sequencer to the TX serializer.
interface cd_tx_sched_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input  out_data, input  out_valid, input  out_last, output out_ready);
endinterface

// File: rtl/cd_tx_sched.sv
// Read-side sequencer for the CDBUS TX ping-pong frame RAM.
// Waits for a committed page and bus permission, reads the frame length,
// streams header+payload to the serializer and handles abort retries.
// Optional build macro CDBUS_TX_TIMEOUT_EN adds a TX-complete watchdog that
// is treated like an arbitration abort when it expires.
module cd_tx_sched
  import cd_tx_pkg::*;
#(
  parameter int A_WIDTH   = 6,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               unread,
  input  logic [7:0]         rd_byte,
  output logic [A_WIDTH+1:0] rd_addr,
  output logic               rd_en,
  output logic               rd_done,
  input  logic               cancel,
  input  logic               tx_permit,
  cd_tx_sched_if.master      tx,
  input  logic               tx_abort,
  input  logic               tx_ok,
  output logic               tx_sent,
  output logic               tx_drop,
  output logic               busy
);

  localparam int BA_W  = A_WIDTH + 2;
  localparam int TOT_W = A_WIDTH + 3;
  localparam logic [TOT_W-1:0] PAGE_BYTES = TOT_W'(1) << BA_W;
  localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRY);

  cd_tx_state_e      state_q, state_d;
  logic [BA_W-1:0]   rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic [7:0]        len_q, len_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              rd_done_q, rd_done_d;
  logic              tx_sent_q, tx_sent_d;
  logic              tx_drop_q, tx_drop_d;

  logic [TOT_W-1:0]  total_cur;
  logic [TOT_W-1:0]  total_new;
  logic [3:0]        retry_inc;
  logic              is_last;
  logic              timeout_hit;
  logic              abort_evt;

  assign total_cur = TOT_W'(len_q)   + TOT_W'(HDR_BYTES);
  assign total_new = TOT_W'(rd_byte) + TOT_W'(HDR_BYTES);
  assign is_last   = ({1'b0, rd_addr_q} == (total_cur - TOT_W'(1)));
  assign retry_inc = retry_q + 4'd1;
  assign abort_evt = (state_q inside {LOAD, SEND, WAIT_DONE}) && (tx_abort || timeout_hit);

  // Next-state and next-output decode; cancel > abort > tx_ok > handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_en_d     = 1'b0;
    len_d       = len_q;
    retry_d     = retry_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rd_done_d   = 1'b0;
    tx_sent_d   = 1'b0;
    tx_drop_d   = 1'b0;

    if (cancel) begin
      state_d     = IDLE;
      retry_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (abort_evt) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      if (retry_inc == RETRY_LIM) begin
        state_d   = IDLE;
        retry_d   = '0;
        rd_done_d = 1'b1;
        tx_drop_d = 1'b1;
      end else begin
        // Page stays owned, so the next grant replays the frame from byte 0.
        state_d = WAIT_GRANT;
        retry_d = retry_inc;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (unread) state_d = WAIT_GRANT;
        end
        WAIT_GRANT: begin
          if (tx_permit) begin
            state_d   = FETCH_LEN;
            rd_en_d   = 1'b1;
            rd_addr_d = BA_W'(LEN_OFS);
          end
        end
        FETCH_LEN: begin
          // First cycle issues the read; rd_byte is valid once rd_en has dropped.
          if (!rd_en_q) begin
            len_d = rd_byte;
            if (total_new > PAGE_BYTES) begin
              state_d   = IDLE;
              retry_d   = '0;
              rd_done_d = 1'b1;
              tx_drop_d = 1'b1;
            end else begin
              state_d   = LOAD;
              rd_addr_d = '0;
              rd_en_d   = 1'b1;
            end
          end
        end
        LOAD: begin
          if (!rd_en_q) begin
            state_d     = SEND;
            out_data_d  = rd_byte;
            out_valid_d = 1'b1;
            out_last_d  = is_last;
          end
        end
        SEND: begin
          if (tx.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (out_last_q) begin
              state_d = WAIT_DONE;
            end else begin
              state_d   = LOAD;
              rd_addr_d = rd_addr_q + BA_W'(1);
              rd_en_d   = 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (tx_ok) begin
            state_d   = IDLE;
            retry_d   = '0;
            rd_done_d = 1'b1;
            tx_sent_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      len_q       <= '0;
      retry_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rd_done_q   <= 1'b0;
      tx_sent_q   <= 1'b0;
      tx_drop_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      len_q       <= len_d;
      retry_q     <= retry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rd_done_q   <= rd_done_d;
      tx_sent_q   <= tx_sent_d;
      tx_drop_q   <= tx_drop_d;
    end
  end

`ifdef CDBUS_TX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt_q;

  // Watchdog restarts whenever WAIT_DONE is entered and counts while there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 to_cnt_q <= '0;
    else if (state_q != WAIT_DONE) to_cnt_q <= '0;
    else                          to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
  end

  assign timeout_hit = (state_q == WAIT_DONE) && (to_cnt_q == '1);
`else
  assign timeout_hit = 1'b0;
`endif

  assign rd_addr      = rd_addr_q;
  assign rd_en        = rd_en_q;
  assign rd_done      = rd_done_q;
  assign tx_sent      = tx_sent_q;
  assign tx_drop      = tx_drop_q;
  assign busy         = (state_q != IDLE);
  assign tx.out_data  = out_data_q;
  assign tx.out_valid = out_valid_q;
  assign tx.out_last  = out_last_q;

endmodule
